// File: rtl/cordic_pkg.sv
// Shared types for the cordic polar stream and the per-window peak result.
// The idx field is sized for the largest supported window; users slice it down.
package cordic_pkg;
    localparam int AMP_W     = 12;
    localparam int PHI_W     = 11;
    localparam int IDX_W_MAX = 16;

    typedef logic        [AMP_W-1:0] amp_t;
    typedef logic signed [PHI_W-1:0] phi_t;

    typedef struct packed {
        amp_t                 amp;
        phi_t                 phi;
        logic [IDX_W_MAX-1:0] idx;
        amp_t                 mean;
    } peak_result_t;

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } pd_state_t;
endpackage

// File: rtl/cordic_result_slot.sv
// One-entry registered valid/ready output slot with a single parked entry
// that refills the slot on the handshake edge, so no bubble appears.
module cordic_result_slot
    import cordic_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  peak_result_t i_data,
    input  logic         i_ready,
    output logic         o_valid,
    output peak_result_t o_data
);
    logic         r_valid;
    logic         r_park_vld;
    peak_result_t r_data;
    peak_result_t r_park;
    logic         w_hs;

    assign w_hs    = r_valid & i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    // Slot/park update: a push lands in the slot if it is free or draining, else parks.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid    <= 1'b0;
            r_park_vld <= 1'b0;
            r_data     <= '0;
            r_park     <= '0;
        end else if (i_push) begin
            if (!r_valid || w_hs) begin
                r_data  <= i_data;
                r_valid <= 1'b1;
            end else begin
                r_park     <= i_data;
                r_park_vld <= 1'b1;
            end
        end else if (w_hs) begin
            if (r_park_vld) begin
                r_data     <= r_park;
                r_park_vld <= 1'b0;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/cordic_peak_detect.sv
// Groups accepted polar samples into WINDOW-sample windows and reports the
// peak amplitude, its phase and index, and the truncated mean amplitude.
module cordic_peak_detect
    import cordic_pkg::*;
#(
    parameter  int WINDOW = 16,
    localparam int IDX_W  = $clog2(WINDOW)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [AMP_W-1:0]        amp_i,
    input  logic signed [PHI_W-1:0] phi_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic                    clear_i,
    output logic [AMP_W-1:0]        peak_amp_o,
    output logic signed [PHI_W-1:0] peak_phi_o,
    output logic [IDX_W-1:0]        peak_idx_o,
    output logic [AMP_W-1:0]        mean_amp_o,
    output logic                    valid_o,
    input  logic                    ready_i
);
    localparam int SUM_W = AMP_W + IDX_W;

    pd_state_t         r_state;
    logic [IDX_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic [SUM_W-1:0]  r_sum;
    amp_t              r_max;
    phi_t              r_phi;

    logic              w_ready;
    logic              w_accept;
    logic              w_first;
    logic              w_last;
    logic              w_push;
    logic              w_slot_valid;
    logic              w_hs;
    logic [SUM_W-1:0]  w_sum_nxt;
    amp_t              w_max_nxt;
    phi_t              w_phi_nxt;
    logic [IDX_W-1:0]  w_idx_nxt;
    peak_result_t      w_res;
    peak_result_t      w_slot_data;
    logic              w_unused_idx_hi;

    assign w_ready  = rst_i && (r_state == ST_ACCUM) && !clear_i;
    assign ready_o  = w_ready;
    assign w_accept = valid_i & w_ready;
    assign w_first  = (r_cnt == {IDX_W{1'b0}});
    assign w_last   = (r_cnt == IDX_W'(WINDOW - 1));
    assign w_push   = w_accept & w_last;
    assign w_hs     = w_slot_valid & ready_i;

    // Running window values including the sample being offered this cycle.
    always_comb begin
        w_sum_nxt = SUM_W'(amp_i);
        w_max_nxt = amp_i;
        w_phi_nxt = phi_i;
        w_idx_nxt = r_cnt;
        if (w_first) begin
            w_idx_nxt = {IDX_W{1'b0}};
        end else if (amp_i > r_max) begin
            w_sum_nxt = r_sum + SUM_W'(amp_i);
        end else begin
            w_sum_nxt = r_sum + SUM_W'(amp_i);
            w_max_nxt = r_max;
            w_phi_nxt = r_phi;
            w_idx_nxt = r_idx;
        end
    end

    assign w_res.amp  = w_max_nxt;
    assign w_res.phi  = w_phi_nxt;
    assign w_res.idx  = IDX_W_MAX'(w_idx_nxt);
    assign w_res.mean = w_sum_nxt[SUM_W-1:IDX_W];

    // Window accumulators; clear only acts while accepting (ACCUM).
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt <= {IDX_W{1'b0}};
            r_idx <= {IDX_W{1'b0}};
            r_sum <= {SUM_W{1'b0}};
            r_max <= {AMP_W{1'b0}};
            r_phi <= {PHI_W{1'b0}};
        end else if (w_accept) begin
            r_cnt <= r_cnt + IDX_W'(1);
            r_idx <= w_idx_nxt;
            r_sum <= w_sum_nxt;
            r_max <= w_max_nxt;
            r_phi <= w_phi_nxt;
        end else if (clear_i && (r_state == ST_ACCUM)) begin
            r_cnt <= {IDX_W{1'b0}};
        end
    end

    // HOLD while a completed window is parked behind an undrained slot.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_ACCUM;
        end else begin
            case (r_state)
                ST_ACCUM: if (w_push && w_slot_valid && !ready_i) r_state <= ST_HOLD;
                ST_HOLD:  if (w_hs) r_state <= ST_ACCUM;
                default:  r_state <= ST_ACCUM;
            endcase
        end
    end

    cordic_result_slot u_slot (
        .i_clk   (clk_i),
        .i_rst_n (rst_i),
        .i_push  (w_push),
        .i_data  (w_res),
        .i_ready (ready_i),
        .o_valid (w_slot_valid),
        .o_data  (w_slot_data)
    );

    assign valid_o         = w_slot_valid;
    assign peak_amp_o      = w_slot_data.amp;
    assign peak_phi_o      = w_slot_data.phi;
    assign peak_idx_o      = w_slot_data.idx[IDX_W-1:0];
    assign mean_amp_o      = w_slot_data.mean;
    assign w_unused_idx_hi = |w_slot_data.idx[IDX_W_MAX-1:IDX_W];
endmodule

// File: doc/cordic_peak_detect.md
Name: cordic_peak_detect

Overview:
Downstream consumer of the cordic stage's polar stream (amp/phi with valid/ready). It groups consecutive accepted samples into fixed windows of WINDOW samples. For each window it reports the peak amplitude, the phase and in-window index at that peak, and the mean amplitude. Results leave through one registered valid/ready output slot so backpressure reaches the cordic stage.

Parameters:
WINDOW, 16, samples per window; power of two, >= 2
AMP_W, 12, amplitude width, unsigned
PHI_W, 11, phase width, signed two's complement (1024 = pi)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; asynchronous, active-low
amp_i  in  AMP_W  amplitude from cordic amp_o
phi_i  in  PHI_W  phase from cordic phi_o
valid_i  in  1  input sample valid
ready_o  out  1  block can accept a sample
clear_i  in  1  synchronous discard of the partial window
peak_amp_o  out  AMP_W  largest amplitude in the window
peak_phi_o  out  PHI_W  phase of the peak sample
peak_idx_o  out  log2(WINDOW)  index 0..WINDOW-1 of the peak sample
mean_amp_o  out  AMP_W  floor(sum of amplitudes / WINDOW)
valid_o  out  1  result valid
ready_i  in  1  downstream accepts result

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_i=0): all outputs 0; counter, sum, max and state cleared; FSM in ACCUM. Reset mid-window or mid-hold discards everything, including an unconsumed result.
- Accept: a sample is accepted when valid_i=1, ready_o=1 and clear_i=0.
- FSM states:
  - ACCUM: ready_o = !clear_i.
  - HOLD: ready_o = 0.
- Sample k=0 of a window: loads max=amp_i, phi_at_max=phi_i, idx=0, sum=amp_i.
- Sample k>0: sum += amp_i. Replace max/phi/idx only if amp_i > max (strict). On a tie the earlier sample is kept.
- Sum width is AMP_W+log2(WINDOW), so it cannot overflow. Mean is sum >> log2(WINDOW), truncated.
- Window completes on sample k=WINDOW-1; the final values include that sample.
  - If the output slot is empty, or is emptied that same cycle (valid_o & ready_i), the result registers into the slot. valid_o=1 on the next cycle (latency 1 clock after the last accept). Counter wraps to 0; stay in ACCUM.
  - Otherwise the completed result is parked internally and the FSM enters HOLD (ready_o=0).
- HOLD exit: on valid_o & ready_i, the parked result moves into the slot on the same edge, valid_o stays 1, and the FSM returns to ACCUM.
- Output slot rules:
  - Once valid_o=1, all result outputs are stable until a handshake.
  - A handshake with no new result ready clears valid_o; result outputs keep their last values.
- clear_i=1 in ACCUM: counter resets to 0 and the partial accumulation is dropped. The output slot is unaffected. A simultaneous valid_i is not accepted, since ready_o=0.
- clear_i in HOLD is ignored; parked results are never discarded.
- Throughput: one sample per clock with no bubble at window boundaries, as long as ready_i keeps the slot drained.

Decomposition:
- Shared package cordic_pkg holds AMP_W and PHI_W defaults, the amp_t and phi_t typedefs, and a peak_result_t struct {amp, phi, idx, mean}.
- Sub-module cordic_result_slot: a one-entry valid/ready register with parked-entry support, instantiated for the output.
- Window accumulation and the FSM stay in the top module.

Test Plan:
1. WINDOW=4, ready_i=1; amps 100,300,200,50 with phis 10,20,30,40 -> one result: peak 300, phi 20, idx 1, mean 162; valid_o rises 1 clock after the 4th accept.
2. Tie: amps 500,500,100,100 with phis -200,300,0,0 -> peak 500, phi -200, idx 0, mean 300.
3. Backpressure: ready_i=0, send 8 samples back-to-back -> first result held stable; ready_o drops after the 8th accept; raising ready_i delivers both results in order with no loss; ready_o returns to 1.
4. Clear: 2 samples (amp 4000), pulse clear_i, then amps 10,20,30,40 -> single result: peak 40, idx 3, mean 25; the 4000 samples are never seen.
5. Saturation: four samples of amp 4095 -> peak 4095, mean 4095, no wrap. Phis 1023,-1024,0,5 -> peak_phi 1023.
6. Reset: assert rst_i asynchronously after 2 samples and while a result is pending -> outputs 0 and valid_o=0 immediately; after release, a fresh 4-sample window produces a correct result.
